lzc_iter: RTL

Iterative, parametrised leading-zero/leading-one counter with valid/ready handshakes on both sides. It scans CHUNK bits per cycle from the MSB and terminates early on the first chunk containing the sought bit. It sits beside the combinational `lzc` in `src/generic` as a low-area option for multi-cycle users such as the divider/sqrt normaliser and the FP-to-int path, where wide single-cycle priority logic does not meet timing.

---
 rtl/lzc_iter.sv | 115 +++++++++++
 1 files changed

// File: rtl/lzc_iter.sv
// Iterative leading-zero/leading-one counter scanning CHUNK bits per cycle from the MSB.
// Optional feature macro LZC_NORM_EN adds the Norm output (In << Count).
module lzc_iter #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] In,
  input  logic             Mode,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [CW-1:0]    Count,
  output logic             AllZero
`ifdef LZC_NORM_EN
  ,
  output logic [WIDTH-1:0] Norm
`endif
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam logic [CW-1:0] LAST_ACC = CW'((NCHUNK - 1) * CHUNK);
  localparam logic [CW-1:0] CHUNK_C  = CW'(CHUNK);
  localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   sr;
  logic [CW-1:0]   acc;
  logic [CHUNK-1:0] top;
  logic [CW-1:0]   top_lz;
  logic            top_zero;
  logic            finish;
  logic [CW-1:0]   acc_next;
`ifdef LZC_NORM_EN
  logic [WIDTH-1:0] in_reg;
`endif

  // LSB padding with ones guarantees a terminating bit and caps the count at WIDTH.
  function automatic logic [PW-1:0] pad_load(input logic [WIDTH-1:0] v);
    logic [PW-1:0] r;
    r = '1;
    r[PW-1 -: WIDTH] = v;
    return r;
  endfunction

  always_comb begin
    top    = sr[PW-1 -: CHUNK];
    top_lz = CHUNK_C;
    for (int i = 0; i < CHUNK; i++) begin
      if (top[i]) top_lz = CW'(CHUNK - 1 - i);
    end
    top_zero = ~|top;
    // Without padding an all-zero vector reaches the last chunk still empty.
    finish   = !top_zero || (acc == LAST_ACC);
    acc_next = acc + top_lz;
  end

  assign InReady = (state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      OutValid <= 1'b0;
      Count    <= '0;
      AllZero  <= 1'b0;
      sr       <= '0;
      acc      <= '0;
`ifdef LZC_NORM_EN
      Norm     <= '0;
      in_reg   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            sr    <= pad_load(In ^ {WIDTH{Mode}});
            acc   <= '0;
`ifdef LZC_NORM_EN
            in_reg <= In;
`endif
            state <= SCAN;
          end
        end
        SCAN: begin
          acc <= acc_next;
          if (finish) begin
            Count    <= acc_next;
            AllZero  <= (acc_next == WIDTH_C);
`ifdef LZC_NORM_EN
            Norm     <= in_reg << acc_next;
`endif
            OutValid <= 1'b1;
            state    <= DONE;
          end else begin
            sr <= sr << CHUNK;
          end
        end
        DONE: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
